// File: rtl/service_arbiter_pkg.sv
// Shared constants for the service arbiter: FSM encoding, service indices, display codes.
package service_arbiter_pkg;

  localparam int unsigned CLOCK_FREQ = 100_000_000;
  localparam int unsigned SEG_W      = 16;

  // Display word shown while no service owns the display.
  localparam logic [SEG_W-1:0] SEG_BLANK = 16'hFFFF;

  // Service slots as wired on the board.
  localparam int unsigned SVC_ALARM     = 0;
  localparam int unsigned SVC_TIMER     = 1;
  localparam int unsigned SVC_STOPWATCH = 2;
  localparam int unsigned SVC_CLOCK     = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/service_arbiter_push_debouncer.sv
// Synchronizes the raw mode button, waits for a stable level and emits one pulse per press.
module push_debouncer
  import service_arbiter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = CLOCK_FREQ / 100
) (
  input  logic clk,
  input  logic reset,
  input  logic push_m_raw,
  output logic push_evt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             last_lvl;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer, stability counter and rising-edge pulse of the stable level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      last_lvl <= 1'b0;
      stable   <= 1'b0;
      cnt      <= '0;
      push_evt <= 1'b0;
    end else begin
      sync1    <= push_m_raw;
      sync2    <= sync1;
      push_evt <= 1'b0;
      if (sync2 != last_lvl) begin
        last_lvl <= sync2;
        cnt      <= '0;
      end else if (cnt == CNT_MAX) begin
        stable   <= last_lvl;
        push_evt <= last_lvl & ~stable;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/service_arbiter.sv
// Shares the 7-segment display and mode button among N services, one owner at a time.
module service_arbiter
  import service_arbiter_pkg::*;
#(
  parameter int unsigned     N_SVC           = 4,
  parameter int unsigned     ID_W            = 2,
  parameter int unsigned     DEBOUNCE_CYCLES = CLOCK_FREQ / 100,
  parameter int unsigned     FINISH_TIMEOUT  = 255,
  parameter logic [SEG_W-1:0] IDLE_SEG       = SEG_BLANK
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SVC-1:0]       spdt,
  input  logic                   push_m_raw,
  input  logic [N_SVC-1:0]       finish,
  input  logic [N_SVC*SEG_W-1:0] seg_in,
  output logic [N_SVC-1:0]       svc_grant,
  output logic [N_SVC-1:0]       push_pulse,
  output logic [SEG_W-1:0]       segments,
  output logic [ID_W-1:0]        active_id,
  output logic                   busy,
  output logic                   conflict
);

  localparam int unsigned TCNT_W = $clog2(FINISH_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(FINISH_TIMEOUT);

  arb_state_t        state;
  arb_state_t        state_n;
  logic [N_SVC-1:0]  spdt_s1;
  logic [N_SVC-1:0]  spdt_s2;
  logic              push_evt;
  logic [TCNT_W-1:0] tcnt;
  logic [TCNT_W-1:0] tcnt_n;
  logic [N_SVC-1:0]  grant_n;
  logic [N_SVC-1:0]  pulse_n;
  logic [ID_W-1:0]   id_n;
  logic              busy_n;
  logic [SEG_W-1:0]  seg_n;
  logic              conflict_n;
  logic [ID_W-1:0]   pick_id;
  logic [SEG_W-1:0]  seg_arr [N_SVC];

  push_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_push_debouncer (
    .clk       (clk),
    .reset     (reset),
    .push_m_raw(push_m_raw),
    .push_evt  (push_evt)
  );

  // Switch synchronizer and registered multi-switch conflict flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spdt_s1  <= '0;
      spdt_s2  <= '0;
      conflict <= 1'b0;
    end else begin
      spdt_s1  <= spdt;
      spdt_s2  <= spdt_s1;
      conflict <= conflict_n;
    end
  end

  // More than one synchronized switch on.
  always_comb begin
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < int'(N_SVC); i++) begin
      if (spdt_s2[i]) ones++;
    end
    conflict_n = (ones > 1);
  end

  // Fixed-priority pick: lowest switched-on index wins.
  always_comb begin
    pick_id = '0;
    for (int i = int'(N_SVC) - 1; i >= 0; i--) begin
      if (spdt_s2[i]) pick_id = ID_W'(i);
    end
  end

  // Unpack the flat segment bus into one word per service.
  always_comb begin
    for (int i = 0; i < int'(N_SVC); i++) begin
      seg_arr[i] = seg_in[i*SEG_W +: SEG_W];
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      svc_grant  <= '0;
      push_pulse <= '0;
      segments   <= IDLE_SEG;
      active_id  <= '0;
      busy       <= 1'b0;
      tcnt       <= '0;
    end else begin
      state      <= state_n;
      svc_grant  <= grant_n;
      push_pulse <= pulse_n;
      segments   <= seg_n;
      active_id  <= id_n;
      busy       <= busy_n;
      tcnt       <= tcnt_n;
    end
  end

  // Next-state and next-output logic; grant is held until release completes.
  always_comb begin
    state_n = state;
    grant_n = svc_grant;
    id_n    = active_id;
    busy_n  = busy;
    pulse_n = '0;
    tcnt_n  = tcnt;
    seg_n   = (state == ST_IDLE) ? IDLE_SEG : seg_arr[active_id];
    case (state)
      ST_IDLE: begin
        if (|spdt_s2) begin
          state_n = ST_GRANT;
          id_n    = pick_id;
          grant_n = N_SVC'(1) << pick_id;
          busy_n  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (push_evt) pulse_n = N_SVC'(1) << active_id;
        if (!spdt_s2[active_id]) begin
          state_n = ST_RELEASE;
          tcnt_n  = '0;
        end
      end
      ST_RELEASE: begin
        if (finish[active_id] || (tcnt == TCNT_MAX)) begin
          state_n = ST_IDLE;
          grant_n = '0;
          id_n    = '0;
          busy_n  = 1'b0;
        end else begin
          tcnt_n = tcnt + TCNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        id_n    = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_service_arbiter.sv
// Directed bench for service_arbiter with a push-pulse scoreboard.
module tb_service_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  spdt;
  logic        push_m_raw;
  logic [3:0]  finish;
  logic [63:0] seg_in;
  logic [3:0]  svc_grant;
  logic [3:0]  push_pulse;
  logic [15:0] segments;
  logic [1:0]  active_id;
  logic        busy;
  logic        conflict;

  int checks = 0;
  int errors = 0;
  logic [3:0] pulse_q [$];

  always #5 clk = ~clk;

  service_arbiter #(
    .N_SVC          (4),
    .ID_W           (2),
    .DEBOUNCE_CYCLES(4),
    .FINISH_TIMEOUT (255),
    .IDLE_SEG       (16'hFFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spdt      (spdt),
    .push_m_raw(push_m_raw),
    .finish    (finish),
    .seg_in    (seg_in),
    .svc_grant (svc_grant),
    .push_pulse(push_pulse),
    .segments  (segments),
    .active_id (active_id),
    .busy      (busy),
    .conflict  (conflict)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for svc_grant to reach a value; returns the number of cycles taken.
  task automatic wait_grant(input logic [3:0] exp, input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (svc_grant === exp) break;
    end
  endtask

  // Every push pulse is matched against the scoreboard; unexpected pulses compare against zero.
  always @(negedge clk) begin
    if (!reset && push_pulse !== 4'b0000) begin
      logic [3:0] exp;
      exp = (pulse_q.size() > 0) ? pulse_q.pop_front() : 4'b0000;
      check("push_pulse", 32'(push_pulse), 32'(exp));
    end
  end

  initial begin
    int n;
    reset      = 1'b1;
    spdt       = 4'b0000;
    push_m_raw = 1'b0;
    finish     = 4'b0000;
    seg_in     = {16'hDDDD, 16'h1234, 16'hBBBB, 16'hAAAA};
    step(3);
    check("rst_grant", 32'(svc_grant), 32'h0);
    check("rst_segments", 32'(segments), 32'hFFFF);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_id", 32'(active_id), 32'h0);
    check("rst_conflict", 32'(conflict), 32'h0);
    reset = 1'b0;
    step(3);
    check("idle_grant", 32'(svc_grant), 32'h0);
    check("idle_segments", 32'(segments), 32'hFFFF);

    // Single switch: grant stopwatch within 4 cycles.
    spdt = 4'b0100;
    wait_grant(4'b0100, 4, n);
    check("grant_id2", 32'(svc_grant), 32'h4);
    check("grant_latency", 32'(n), 32'd3);
    check("active_id2", 32'(active_id), 32'd2);
    check("busy_grant", 32'(busy), 32'h1);
    check("no_conflict", 32'(conflict), 32'h0);
    step(1);
    check("seg_mux", 32'(segments), 32'h1234);
    seg_in[15:0]  = 16'h5555;
    seg_in[63:48] = 16'h6666;
    step(2);
    check("seg_other_ignored", 32'(segments), 32'h1234);
    seg_in[47:32] = 16'h4321;
    step(2);
    check("seg_follow", 32'(segments), 32'h4321);

    // Bouncy press then hold: exactly one pulse on bit 2.
    pulse_q.push_back(4'b0100);
    repeat (3) begin
      push_m_raw = 1'b1; step(2);
      push_m_raw = 1'b0; step(2);
    end
    push_m_raw = 1'b1;
    step(20);
    push_m_raw = 1'b0;
    step(12);
    check("pulse_drained", 32'(pulse_q.size()), 32'd0);

    // Release without finish: forced release after the timeout.
    spdt = 4'b0000;
    wait_grant(4'b0000, 400, n);
    check("timeout_grant", 32'(svc_grant), 32'h0);
    check("timeout_cycles", 32'(n), 32'd259);
    check("timeout_busy", 32'(busy), 32'h0);
    check("timeout_id", 32'(active_id), 32'h0);
    step(1);
    check("timeout_seg", 32'(segments), 32'hFFFF);

    // Two switches: lowest index wins, conflict flagged, no preemption.
    spdt = 4'b0110;
    wait_grant(4'b0010, 6, n);
    check("prio_grant", 32'(svc_grant), 32'h2);
    check("prio_id", 32'(active_id), 32'd1);
    check("conflict_on", 32'(conflict), 32'h1);
    step(3);
    check("no_preempt", 32'(svc_grant), 32'h2);
    // Drop timer with finish already high: one RELEASE cycle, one IDLE cycle, then stopwatch.
    spdt   = 4'b0100;
    finish = 4'b0010;
    step(3);
    check("release_held", 32'(svc_grant), 32'h2);
    step(1);
    check("finish_release", 32'(svc_grant), 32'h0);
    finish = 4'b0000;
    step(1);
    check("regrant_id2", 32'(svc_grant), 32'h4);
    check("regrant_active", 32'(active_id), 32'd2);
    check("conflict_off", 32'(conflict), 32'h0);

    // Reset in RELEASE: outputs clear asynchronously; presses in IDLE are dropped.
    spdt = 4'b0000;
    step(6);
    check("rel_busy", 32'(busy), 32'h1);
    check("rel_grant_held", 32'(svc_grant), 32'h4);
    #2 reset = 1'b1;
    #1;
    check("async_grant", 32'(svc_grant), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_seg", 32'(segments), 32'hFFFF);
    check("async_id", 32'(active_id), 32'h0);
    push_m_raw = 1'b1;
    step(3);
    reset = 1'b0;
    push_m_raw = 1'b0;
    step(3);
    push_m_raw = 1'b1;
    step(15);
    push_m_raw = 1'b0;
    step(10);
    check("idle_after_reset", 32'(svc_grant), 32'h0);
    check("idle_no_pulse_q", 32'(pulse_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/service_arbiter.md
Name: service_arbiter

Overview:
Top-level scheduler that shares the single 4-digit 7-segment display and the single push_m button among N service blocks (alarm, timer, stopwatch, ...).
- Grants exactly one service at a time, selected by its SPDT switch.
- Debounces push_m into a one-cycle pulse routed only to the granted service.
- Muxes the granted service's 16-bit BCD segment word to the display.
- Waits for the service's finish handshake before re-arbitrating.

Parameters:
N_SVC, 4, number of services (2..8)
ID_W, 2, width of service index (clog2(N_SVC))
DEBOUNCE_CYCLES, 1_000_000, cycles push_m must be stable (10 ms at 100 MHz)
FINISH_TIMEOUT, 255, max cycles to wait for finish before forced release
IDLE_SEG, 16'hFFFF, display word when no service is granted (blank code)

Ports:
clk  in  1  main clock, 100 MHz
reset  in  1  asynchronous, active-high reset
spdt  in  N_SVC  raw SPDT switch levels, one per service
push_m_raw  in  1  raw mode push button (bouncy, asynchronous)
finish  in  N_SVC  finish flags from services (level)
seg_in  in  N_SVC*16  BCD segment words, service i at [16i+15:16i]
svc_grant  out  N_SVC  one-hot enable to services; all zero when idle
push_pulse  out  N_SVC  one-cycle debounced push, only on the granted bit
segments  out  16  display word to the 7-segment driver
active_id  out  ID_W  index of granted service (0 when idle)
busy  out  1  high in GRANT or RELEASE
conflict  out  1  high while more than one spdt bit is on

Behaviour:
- Reset values (asynchronous): state=IDLE; svc_grant=0, push_pulse=0, segments=IDLE_SEG, active_id=0, busy=0, conflict=0; debounce counter, synchronizers and timeout counter cleared.
- Input synchronization:
  - spdt and push_m_raw pass through 2-FF synchronizers.
  - FSM sees spdt 2 cycles late.
- Debounce:
  - Counter resets on any change of the synchronized push level.
  - Stable level is updated when the counter reaches DEBOUNCE_CYCLES-1.
  - A rising edge of the stable level produces a 1-cycle internal pulse.
  - Holding the button gives exactly one pulse.
- FSM states: IDLE, GRANT, RELEASE.
  - IDLE:
    - If any synced spdt bit is on, grant the lowest index i (fixed priority).
    - Next cycle: state=GRANT, active_id=i, svc_grant=1<<i, busy=1.
  - GRANT:
    - No preemption: other spdt bits are ignored (conflict may assert).
    - Internal push pulse drives push_pulse[active_id] for exactly 1 cycle.
    - Pulses in IDLE and RELEASE are dropped.
    - When synced spdt[active_id] goes 0: state=RELEASE, timeout counter=0, svc_grant still held.
  - RELEASE:
    - Exit when finish[active_id]=1 or the counter reaches FINISH_TIMEOUT.
    - On exit: state=IDLE, svc_grant=0, active_id=0, busy=0.
    - Guaranteed at least 1 IDLE cycle between grants.
    - If spdt[active_id] returns to 1 in RELEASE, still complete the release; re-arbitration happens from IDLE.
- segments (registered, 1-cycle latency):
  - seg_in slice of active_id in GRANT and RELEASE.
  - IDLE_SEG in IDLE.
- conflict: registered popcount(synced spdt)>1, updated every cycle in all states.
- Simultaneous events:
  - spdt drop and push pulse in the same GRANT cycle: pulse is delivered, then state moves to RELEASE.
  - finish already high on entry to RELEASE: exit after 1 cycle.
- Reset mid-operation: immediate return to reset values; pending debounce is discarded.

Decomposition:
- Shared package: state encoding constants (IDLE/GRANT/RELEASE), service index constants (ALARM/TIMER/STOPWATCH/...), IDLE_SEG blank code, CLOCK_FREQ.
- One sub-module, push_debouncer: synchronizer, stability counter and edge-pulse generator. Its DEBOUNCE_CYCLES parameter is overridden to 4 in simulation.
- Priority encoder and segment mux stay inline.

Test Plan:
1. Reset, spdt=0000 -> svc_grant=0, segments=16'hFFFF, busy=0; after setting spdt=0100, svc_grant=0100 and active_id=2 within 4 cycles.
2. spdt=0110 simultaneously -> grant 0010 (id 1), conflict=1; later clear spdt[1] and pulse finish[1] -> after the IDLE cycle, grant moves to 0100.
3. Granted id 2, seg_in[47:32]=16'h1234 -> segments=16'h1234 one cycle after GRANT; other seg_in changes have no effect.
4. push_m_raw bounces 3 times (2 cycles each), then holds high (DEBOUNCE_CYCLES=4) -> exactly one push_pulse[2] of 1 cycle; no pulse on other bits.
5. Clear spdt[2] with finish held 0 -> svc_grant held for FINISH_TIMEOUT cycles (255), then returns to 0.
6. Assert reset while in RELEASE -> all outputs return to reset values asynchronously; push presses during IDLE produce no pulse.
